// File: rtl/quad_input_filter.sv
// ---------------------------------------------------------------------------
// quad_input_filter
//
// Front-end conditioner for raw quadrature encoder pins. Each pin is
// synchronised into the aclk domain and passed through a glitch filter. The
// filtered pair is then decoded into a one-cycle step pulse, a direction bit
// and an illegal-transition pulse. The filtered levels drive
// encoder_axi.enc_a / enc_b downstream.
//
// Optional feature (compile-time macro QIF_ERR_COUNT_EN):
//   defined   : err_count counts err_pulse events and saturates at all-ones.
//               clr_err clears it, and a clear wins over a simultaneous error.
//   undefined : no counter logic. err_count is tied to 0 and clr_err is
//               ignored. err_pulse is still generated.
//   The port list is identical in both builds.
//
// Parameters
//   SYNC_STAGES : synchroniser depth per pin (>= 2)
//   FILT_LEN    : consecutive disagreeing samples needed to flip a filtered
//                 output (>= 1)
//   ERR_CNT_W   : width of the illegal-transition counter
//
// Ports
//   aclk      in   system clock
//   aresetn   in   asynchronous active-low reset
//   enable    in   1 = step / err_pulse / counting active
//   clr_err   in   synchronous clear of err_count
//   enc_a_raw in   raw channel A pin (asynchronous)
//   enc_b_raw in   raw channel B pin (asynchronous)
//   enc_a_f   out  filtered A
//   enc_b_f   out  filtered B
//   step      out  one-cycle pulse per legal filtered transition
//   dir       out  1 = forward (00->01->11->10->00), 0 = backward
//   err_pulse out  one-cycle pulse when both filtered bits change together
//   err_count out  saturating count of err_pulse events
//
// Latency: a raw level first captured at edge E0 and held reaches enc_*_f at
// edge E0+SYNC_STAGES+FILT_LEN-1. The matching step/err_pulse appears one edge
// later, because the decoder compares the filtered pair against its registered
// copy.
// ---------------------------------------------------------------------------
module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic                 clr_err,
    input  logic                 enc_a_raw,
    input  logic                 enc_b_raw,
    output logic                 enc_a_f,
    output logic                 enc_b_f,
    output logic                 step,
    output logic                 dir,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

    // The counter must hold values 0..FILT_LEN-1. It keeps at least one bit,
    // so FILT_LEN == 1 still elaborates; in that case the filter flips on the
    // first disagreeing sample.
    localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    // ------------------------------------------------------------------
    // Synchronisers. Bit 0 captures the raw pin, and the MSB is the
    // synchronised level.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic                   s_a;
    logic                   s_b;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a_raw};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b_raw};
        end
    end

    assign s_a = sync_a[SYNC_STAGES-1];
    assign s_b = sync_b[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filters. The counter tracks how many consecutive samples
    // disagree with the current filtered level. Any agreeing sample
    // restarts the count, so a pulse shorter than FILT_LEN samples never
    // reaches the output. These filters run regardless of enable, so the
    // filtered levels always follow the pins.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            enc_a_f <= 1'b0;
            cnt_a   <= '0;
        end else if (s_a == enc_a_f) begin
            cnt_a <= '0;
        end else if (cnt_a == CNT_LAST) begin
            enc_a_f <= s_a;
            cnt_a   <= '0;
        end else begin
            cnt_a <= cnt_a + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            enc_b_f <= 1'b0;
            cnt_b   <= '0;
        end else if (s_b == enc_b_f) begin
            cnt_b <= '0;
        end else if (cnt_b == CNT_LAST) begin
            enc_b_f <= s_b;
            cnt_b   <= '0;
        end else begin
            cnt_b <= cnt_b + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Decoder. prev follows the filtered pair on every edge, even while
    // disabled. Because of that, re-enabling with static pins cannot
    // produce a stale step.
    // ------------------------------------------------------------------
    logic [1:0] cur;
    logic [1:0] prev;
    logic [1:0] diff;
    logic       one_bit;
    logic       both_bits;
    logic       is_fwd;
    logic       step_d;
    logic       err_d;
    logic       dir_d;

    // Forward successor of a Gray state in the 00->01->11->10->00 cycle.
    function automatic logic [1:0] fwd_next(input logic [1:0] q);
        logic [1:0] n;
        case (q)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    assign cur = {enc_a_f, enc_b_f};

    always_comb begin
        diff      = cur ^ prev;
        one_bit   = (diff == 2'b01) || (diff == 2'b10);
        both_bits = (diff == 2'b11);
        is_fwd    = (cur == fwd_next(prev));
        step_d    = enable && one_bit;
        err_d     = enable && both_bits;
        dir_d     = dir;
        // Direction only updates on a legal, enabled step.
        if (step_d) begin
            dir_d = is_fwd;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev      <= 2'b00;
            step      <= 1'b0;
            err_pulse <= 1'b0;
            dir       <= 1'b0;
        end else begin
            prev      <= cur;
            step      <= step_d;
            err_pulse <= err_d;
            dir       <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Error counter. The counter increments on the same edge that raises
    // err_pulse, so err_count already includes an event while its pulse is
    // visible. A clear on that edge takes priority.
    // ------------------------------------------------------------------
`ifdef QIF_ERR_COUNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (err_d && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    // clr_err has no effect in this build.
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign err_count      = '0;
`endif

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter (defaults SYNC_STAGES=2, FILT_LEN=4,
// ERR_CNT_W=4 so saturation is reachable). Inputs change 1 ns after a rising
// edge and are captured at the next edge. After "tick(k)" the bench sits 1 ns
// past the k-th edge since the inputs last changed, where it samples outputs.
module tb_quad_input_filter;

    localparam int ERR_CNT_W = 4;
`ifdef QIF_ERR_COUNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic                 aclk;
    logic                 aresetn;
    logic                 enable;
    logic                 clr_err;
    logic                 enc_a_raw;
    logic                 enc_b_raw;
    logic                 enc_a_f;
    logic                 enc_b_f;
    logic                 step;
    logic                 dir;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    int n_cmp = 0;
    int n_err = 0;
    int step_cnt = 0;
    int err_cnt = 0;
    bit step_q = 1'b0;
    bit err_q = 1'b0;

    quad_input_filter #(
        .SYNC_STAGES(2),
        .FILT_LEN   (4),
        .ERR_CNT_W  (ERR_CNT_W)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .enable   (enable),
        .clr_err  (clr_err),
        .enc_a_raw(enc_a_raw),
        .enc_b_raw(enc_b_raw),
        .enc_a_f  (enc_a_f),
        .enc_b_f  (enc_b_f),
        .step     (step),
        .dir      (dir),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    // clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic set_raw(input logic [1:0] v);
        {enc_a_raw, enc_b_raw} = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: counts pulses, checks that step and err_pulse are never
    // high together, and checks that neither pulse stays high two cycles.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (step) step_cnt++;
            if (err_pulse) err_cnt++;
            if (step || err_pulse) begin
                n_cmp++;
                assert (!(step && err_pulse) && !(step && step_q) && !(err_pulse && err_q)) else begin
                    n_err++;
                    $error("FAIL pulse_shape: step=%0b err=%0b prev_step=%0b prev_err=%0b",
                           step, err_pulse, step_q, err_q);
                end
            end
            step_q = step;
            err_q  = err_pulse;
        end
    end

    logic [1:0] fwd_seq [4];
    logic [1:0] bwd_seq [4];
    int s0;
    int e0;

    initial begin
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        bwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        aresetn = 1'b0; enable = 1'b0; clr_err = 1'b0;
        set_raw(2'b11);

        // 1: reset with raw=11, then release
        tick(3);
        check("rst_a_f", enc_a_f, 0);
        check("rst_b_f", enc_b_f, 0);
        check("rst_step", step, 0);
        check("rst_dir", dir, 0);
        check("rst_err", err_pulse, 0);
        check("rst_cnt", err_count, 0);
        aresetn = 1'b1;
        tick(5);
        check("rel_ab_before", {enc_a_f, enc_b_f}, 2'b00);
        tick(1);
        check("rel_ab_after", {enc_a_f, enc_b_f}, 2'b11);

        // clean restart from 00, then enable
        aresetn = 1'b0;
        set_raw(2'b00);
        tick(2);
        check("rerst_ab", {enc_a_f, enc_b_f}, 2'b00);
        aresetn = 1'b1;
        enable = 1'b1;
        tick(10);

        // 2: glitch of 3 clocks is rejected
        s0 = step_cnt;
        enc_a_raw = 1'b1; tick(3); enc_a_raw = 1'b0; tick(10);
        check("glitch3_a_f", enc_a_f, 0);
        check("glitch3_steps", step_cnt - s0, 0);
        // 4-clock pulse passes: rise at E0+5 (00->10 backward), fall at E0+9 (10->00 forward)
        enc_a_raw = 1'b1; tick(4); enc_a_raw = 1'b0;
        tick(1);
        check("pulse4_a_f_e4", enc_a_f, 0);
        tick(1);
        check("pulse4_a_f_e5", enc_a_f, 1);
        tick(1);
        check("pulse4_step_rise", step, 1);
        check("pulse4_dir_rise", dir, 0);
        tick(1);
        check("pulse4_step_gone", step, 0);
        tick(2);
        check("pulse4_a_f_e9", enc_a_f, 0);
        tick(1);
        check("pulse4_step_fall", step, 1);
        check("pulse4_dir_fall", dir, 1);
        tick(4);
        check("pulse4_steps", step_cnt - s0, 2);

        // 3: forward, 5 cycles -> 20 steps
        s0 = step_cnt; e0 = err_cnt;
        for (int c = 0; c < 5; c++)
            for (int i = 0; i < 4; i++) begin
                set_raw(fwd_seq[i]);
                tick(8);
            end
        tick(4);
        check("fwd_steps", step_cnt - s0, 20);
        check("fwd_dir", dir, 1);
        check("fwd_errs", err_cnt - e0, 0);

        // 4: backward, 10 cycles -> 40 steps
        s0 = step_cnt;
        for (int c = 0; c < 10; c++)
            for (int i = 0; i < 4; i++) begin
                set_raw(bwd_seq[i]);
                tick(8);
            end
        tick(4);
        check("bwd_steps", step_cnt - s0, 40);
        check("bwd_dir", dir, 0);

        // 5: illegal 00->11
        s0 = step_cnt; e0 = err_cnt;
        set_raw(2'b11);
        tick(6);
        check("ill_err_before", err_pulse, 0);
        tick(1);
        check("ill_err", err_pulse, 1);
        check("ill_step", step, 0);
        check("ill_dir", dir, 0);
        check("ill_cnt1", err_count, HAS_CNT ? 1 : 0);
        tick(1);
        check("ill_err_gone", err_pulse, 0);
        tick(6);
        // 19 more errors -> 20 total, counter saturates at 15
        for (int k = 0; k < 19; k++) begin
            set_raw((k % 2 == 0) ? 2'b00 : 2'b11);
            tick(8);
        end
        check("sat_pulses", err_cnt - e0, 20);
        check("sat_steps", step_cnt - s0, 0);
        check("sat_cnt", err_count, HAS_CNT ? 15 : 0);
        check("sat_dir", dir, 0);
        // clear on the same edge as an error: clear wins (state 00 -> 11)
        set_raw(2'b11);
        tick(6);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_err_pulse", err_pulse, 1);
        check("clr_cnt", err_count, 0);
        tick(8);
        check("clr_cnt_hold", err_count, 0);

        // 6: disabled forward transitions from 11
        s0 = step_cnt; e0 = err_cnt;
        enable = 1'b0;
        set_raw(2'b10); tick(8); check("dis_ab_10", {enc_a_f, enc_b_f}, 2'b10);
        set_raw(2'b00); tick(8); check("dis_ab_00", {enc_a_f, enc_b_f}, 2'b00);
        set_raw(2'b01); tick(8); check("dis_ab_01", {enc_a_f, enc_b_f}, 2'b01);
        set_raw(2'b11); tick(8); check("dis_ab_11", {enc_a_f, enc_b_f}, 2'b11);
        check("dis_steps", step_cnt - s0, 0);
        check("dis_errs", err_cnt - e0, 0);
        check("dis_dir", dir, 0);
        enable = 1'b1;
        tick(10);
        check("reen_steps", step_cnt - s0, 0);
        set_raw(2'b10);
        tick(8);
        check("reen_one_step", step_cnt - s0, 1);
        check("reen_dir", dir, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
